// File: rtl/pll_lock_controller_if.sv
// PLL control bundle: PLL lock/restart inputs and reset/status outputs of the lock controller.
interface pll_lock_controller_if #(
  parameter int CNT_W = 8
);
  logic             locked_i;
  logic             restart_i;
  logic             pll_rst_o;
  logic             sys_resetn_o;
  logic             ready_o;
  logic             fault_o;
  logic [CNT_W-1:0] loss_count_o;

  modport master (
    input  locked_i, restart_i,
    output pll_rst_o, sys_resetn_o, ready_o, fault_o, loss_count_o
  );

  modport slave (
    output locked_i, restart_i,
    input  pll_rst_o, sys_resetn_o, ready_o, fault_o, loss_count_o
  );
endinterface

// File: rtl/pll_lock_controller.sv
// PLL reset/lock sequencer: reset window, lock wait with timeout/retry, lock debounce,
// system reset release, run-time loss-of-lock recovery and sticky fault.
module pll_lock_controller #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input logic                  clock_i,
  input logic                  resetn_i,
  pll_lock_controller_if.master pll
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAXC  = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int RW    = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TW-1:0]    RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]    LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    STAB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [2:0] {
    RST_ASSERT,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_e;

  state_e           state_q, state_nx;
  logic [TW-1:0]    timer_q, timer_nx;
  logic [RW-1:0]    retry_q, retry_nx, retry_inc;
  logic [CNT_W-1:0] loss_q, loss_nx;
  logic [1:0]       sync_pipe;
  logic             locked_s;
  logic             pll_rst_q, sys_resetn_q, ready_q, fault_q;

  // locked_i comes from the PLL's own timing domain
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) sync_pipe <= '0;
    else           sync_pipe <= {sync_pipe[0], pll.locked_i};
  end
  assign locked_s  = sync_pipe[1];
  assign retry_inc = retry_q + 1'b1;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= RST_ASSERT;
      timer_q <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_nx;
      timer_q <= timer_nx;
      retry_q <= retry_nx;
      loss_q  <= loss_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    timer_nx = timer_q;
    retry_nx = retry_q;
    loss_nx  = loss_q;
    if (pll.restart_i) begin
      state_nx = RST_ASSERT;
      timer_nx = '0;
      retry_nx = '0;
    end else begin
      unique case (state_q)
        RST_ASSERT: begin
          if (timer_q == RST_LAST) begin
            state_nx = WAIT_LOCK;
            timer_nx = '0;
          end else begin
            timer_nx = timer_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nx = STABLE;
            timer_nx = '0;
          end else if (timer_q == LOCK_LAST) begin
            timer_nx = '0;
            retry_nx = retry_inc;
            state_nx = (retry_inc == RETRY_MAX) ? FAULT : RST_ASSERT;
          end else begin
            timer_nx = timer_q + 1'b1;
          end
        end
        STABLE: begin
          // a dropout here is a glitch, not a failed attempt: retries untouched
          if (!locked_s) begin
            state_nx = WAIT_LOCK;
            timer_nx = '0;
          end else if (timer_q == STAB_LAST) begin
            state_nx = RUN;
            timer_nx = '0;
            retry_nx = '0;
          end else begin
            timer_nx = timer_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_nx = RST_ASSERT;
            timer_nx = '0;
            if (loss_q != CNT_SAT) loss_nx = loss_q + 1'b1;
          end
        end
        FAULT: ;
        default: begin
          state_nx = RST_ASSERT;
          timer_nx = '0;
        end
      endcase
    end
  end

  // Outputs decoded from next state so they change on the same edge as the state
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pll_rst_q    <= 1'b1;
      sys_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pll_rst_q    <= (state_nx == RST_ASSERT) || (state_nx == FAULT);
      sys_resetn_q <= (state_nx == RUN);
      ready_q      <= (state_nx == RUN);
      fault_q      <= (state_nx == FAULT);
    end
  end

  assign pll.pll_rst_o    = pll_rst_q;
  assign pll.sys_resetn_o = sys_resetn_q;
  assign pll.ready_o      = ready_q;
  assign pll.fault_o      = fault_q;
  assign pll.loss_count_o = loss_q;

endmodule

// File: tb/tb_pll_lock_controller.sv
// Directed bench for pll_lock_controller (RST=4, TIMEOUT=32, STABLE=8, RETRIES=2).
// Period k = interval after the k-th rising edge following the event that starts a test.
module tb_pll_lock_controller;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pll_lock_controller_if #(.CNT_W(CNT_W)) bus ();

  pll_lock_controller #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .MAX_RETRIES(2), .CNT_W(CNT_W)
  ) dut (
    .clock_i (clk),
    .resetn_i(resetn),
    .pll     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.locked_i = 1'b0;
    bus.restart_i = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    total++; if (bus.pll_rst_o !== 1'b1) begin bad++; $display("FAIL reset_pll_rst: got=%b want=1", bus.pll_rst_o); end
    total++; if (bus.sys_resetn_o !== 1'b0) begin bad++; $display("FAIL reset_sys_resetn: got=%b want=0", bus.sys_resetn_o); end
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b want=0", bus.ready_o); end
    total++; if (bus.fault_o !== 1'b0) begin bad++; $display("FAIL reset_fault: got=%b want=0", bus.fault_o); end
    total++; if (bus.loss_count_o !== 8'd0) begin bad++; $display("FAIL reset_loss: got=%0d want=0", bus.loss_count_o); end
  endtask

  // Lock at period 10 -> locked_s at 12 -> STABLE 13..20 -> RUN at 21
  task automatic test_lock();
    logic [30:0] pr;
    int srise = -1, rrise = -1;
    bit fault_seen = 0;
    resetn = 1'b1;
    pr[0] = bus.pll_rst_o;
    total++; if (bus.sys_resetn_o !== 1'b0) begin bad++; $display("FAIL lock_sysrst_p0: got=%b want=0", bus.sys_resetn_o); end
    for (int k = 1; k <= 30; k++) begin
      tick();
      pr[k] = bus.pll_rst_o;
      if (srise < 0 && bus.sys_resetn_o) srise = k;
      if (rrise < 0 && bus.ready_o) rrise = k;
      if (bus.fault_o) fault_seen = 1;
      if (k == 10) bus.locked_i = 1'b1;
    end
    total++; if (pr !== 31'h0000_000F) begin bad++; $display("FAIL lock_pll_rst_window: got=%h want=0000000f", pr); end
    total++; if (srise != 21) begin bad++; $display("FAIL lock_sysrst_rise: got=%0d want=21", srise); end
    total++; if (rrise != 21) begin bad++; $display("FAIL lock_ready_rise: got=%0d want=21", rrise); end
    total++; if (fault_seen) begin bad++; $display("FAIL lock_fault: got=1 want=0"); end
  endtask

  // RST 0-3, WAIT 4-35, RST 36-39, WAIT 40-71, FAULT from 72
  task automatic test_timeout();
    logic [80:0] pr, exp_pr;
    int frise = -1;
    bit srst_seen = 0;
    for (int k = 0; k <= 80; k++)
      exp_pr[k] = (k <= 3) || (k >= 36 && k <= 39) || (k >= 72);
    bus.locked_i = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    pr[0] = bus.pll_rst_o;
    for (int k = 1; k <= 80; k++) begin
      tick();
      pr[k] = bus.pll_rst_o;
      if (frise < 0 && bus.fault_o) frise = k;
      if (bus.sys_resetn_o || bus.ready_o) srst_seen = 1;
    end
    total++; if (pr !== exp_pr) begin bad++; $display("FAIL timeout_pll_rst: got=%h want=%h", pr, exp_pr); end
    total++; if (frise != 72) begin bad++; $display("FAIL timeout_fault_rise: got=%0d want=72", frise); end
    total++; if (srst_seen) begin bad++; $display("FAIL timeout_sysrst: got=1 want=0"); end
    bus.locked_i = 1'b1;
    repeat (40) tick();
    total++; if (bus.fault_o !== 1'b1) begin bad++; $display("FAIL fault_sticky: got=%b want=1", bus.fault_o); end
    total++; if (bus.pll_rst_o !== 1'b1) begin bad++; $display("FAIL fault_pll_rst: got=%b want=1", bus.pll_rst_o); end
    total++; if (bus.sys_resetn_o !== 1'b0 || bus.ready_o !== 1'b0) begin bad++; $display("FAIL fault_outputs: sysrst=%b ready=%b want=0 0", bus.sys_resetn_o, bus.ready_o); end
  endtask

  // Restart in FAULT: RST 1-4, WAIT 5, STABLE 6-13, RUN 14
  task automatic test_restart_fault();
    logic [20:0] pr;
    int rrise = -1;
    pr[0] = 1'b0;
    bus.restart_i = 1'b1;
    tick();
    bus.restart_i = 1'b0;
    pr[1] = bus.pll_rst_o;
    total++; if (bus.fault_o !== 1'b0) begin bad++; $display("FAIL restart_fault_clear: got=%b want=0", bus.fault_o); end
    for (int j = 2; j <= 20; j++) begin
      tick();
      pr[j] = bus.pll_rst_o;
      if (rrise < 0 && bus.ready_o) rrise = j;
    end
    total++; if (pr !== 21'h1E) begin bad++; $display("FAIL restart_fault_pulse: got=%h want=1e", pr); end
    total++; if (rrise != 14) begin bad++; $display("FAIL restart_fault_run: got=%0d want=14", rrise); end
  endtask

  // Glitch at STABLE period 11 after 5 good cycles; RUN at 21, no extra pulse
  task automatic test_glitch();
    logic [30:0] pr;
    int rrise = -1;
    bit fault_seen = 0;
    pr[0] = 1'b0;
    bus.restart_i = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      tick();
      pr[j] = bus.pll_rst_o;
      if (rrise < 0 && bus.ready_o) rrise = j;
      if (bus.fault_o) fault_seen = 1;
      if (j == 1) bus.restart_i = 1'b0;
      if (j == 9) bus.locked_i = 1'b0;
      if (j == 10) bus.locked_i = 1'b1;
    end
    total++; if (pr !== 31'h1E) begin bad++; $display("FAIL glitch_pll_rst: got=%h want=1e", pr); end
    total++; if (rrise != 21) begin bad++; $display("FAIL glitch_run_entry: got=%0d want=21", rrise); end
    total++; if (fault_seen) begin bad++; $display("FAIL glitch_fault: got=1 want=0"); end
  endtask

  // Restart lands in the same cycle locked_s falls in RUN: no loss counted
  task automatic test_restart_run();
    bit got_ready = 0;
    total++; if (bus.loss_count_o !== 8'd0) begin bad++; $display("FAIL rrun_loss_before: got=%0d want=0", bus.loss_count_o); end
    bus.locked_i = 1'b0;
    tick();
    tick();
    bus.restart_i = 1'b1;
    tick();
    bus.restart_i = 1'b0;
    total++; if (bus.loss_count_o !== 8'd0) begin bad++; $display("FAIL rrun_loss_after: got=%0d want=0", bus.loss_count_o); end
    total++; if (bus.ready_o !== 1'b0 || bus.pll_rst_o !== 1'b1) begin bad++; $display("FAIL rrun_outputs: ready=%b pll_rst=%b want=0 1", bus.ready_o, bus.pll_rst_o); end
    bus.locked_i = 1'b1;
    for (int j = 0; j < 30 && !got_ready; j++) begin
      tick();
      if (bus.ready_o) got_ready = 1;
    end
    total++; if (!got_ready) begin bad++; $display("FAIL rrun_relock: got=timeout want=ready"); end
    total++; if (bus.loss_count_o !== 8'd0) begin bad++; $display("FAIL rrun_loss_final: got=%0d want=0", bus.loss_count_o); end
  endtask

  // Drop at p: locked_s low p+2, RST 3-6, relock, RUN at 16
  task automatic test_loss_drop();
    logic [20:0] pr;
    int rrise = -1;
    pr[0] = 1'b0;
    bus.locked_i = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      pr[j] = bus.pll_rst_o;
      if (j == 2) begin
        total++; if (bus.sys_resetn_o !== 1'b1 || bus.loss_count_o !== 8'd0) begin bad++; $display("FAIL drop_early: sysrst=%b loss=%0d want=1 0", bus.sys_resetn_o, bus.loss_count_o); end
      end
      if (j == 3) begin
        total++; if (bus.sys_resetn_o !== 1'b0 || bus.ready_o !== 1'b0) begin bad++; $display("FAIL drop_sysrst: sysrst=%b ready=%b want=0 0", bus.sys_resetn_o, bus.ready_o); end
        total++; if (bus.loss_count_o !== 8'd1) begin bad++; $display("FAIL drop_loss: got=%0d want=1", bus.loss_count_o); end
        bus.locked_i = 1'b1;
      end
      if (j > 3 && rrise < 0 && bus.ready_o) rrise = j;
    end
    total++; if (pr !== 21'h78) begin bad++; $display("FAIL drop_pll_rst: got=%h want=78", pr); end
    total++; if (rrise != 16) begin bad++; $display("FAIL drop_rerun: got=%0d want=16", rrise); end
  endtask

  task automatic test_saturate();
    bit hung = 0;
    bit got_ready;
    for (int n = 2; n <= 300; n++) begin
      bus.locked_i = 1'b0;
      repeat (3) tick();
      bus.locked_i = 1'b1;
      got_ready = 0;
      for (int j = 0; j < 40 && !got_ready; j++) begin
        tick();
        if (bus.ready_o) got_ready = 1;
      end
      if (!got_ready) hung = 1;
      if (n == 100) begin
        total++; if (bus.loss_count_o !== 8'd100) begin bad++; $display("FAIL sat_loss_100: got=%0d want=100", bus.loss_count_o); end
      end
    end
    total++; if (hung) begin bad++; $display("FAIL sat_relock: got=timeout want=ready"); end
    total++; if (bus.loss_count_o !== 8'd255) begin bad++; $display("FAIL sat_loss_final: got=%0d want=255", bus.loss_count_o); end
  endtask

  task automatic test_reset_midrun();
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL midrun_pre_ready: got=%b want=1", bus.ready_o); end
    #2;
    resetn = 1'b0;
    #1;
    total++; if (bus.pll_rst_o !== 1'b1) begin bad++; $display("FAIL midrun_pll_rst: got=%b want=1", bus.pll_rst_o); end
    total++; if (bus.sys_resetn_o !== 1'b0 || bus.ready_o !== 1'b0) begin bad++; $display("FAIL midrun_sysrst: sysrst=%b ready=%b want=0 0", bus.sys_resetn_o, bus.ready_o); end
    total++; if (bus.loss_count_o !== 8'd0) begin bad++; $display("FAIL midrun_loss: got=%0d want=0", bus.loss_count_o); end
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_timeout();
    test_restart_fault();
    test_glitch();
    test_restart_run();
    test_loss_drop();
    test_saturate();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
